// File: rtl/ov7670_frame_writer.sv
// ov7670_frame_writer: OV7670 byte-stream to RGB565 frame-buffer write port
// Ports: clk (camera PCLK), reset_n (async active-low), vsync/href/data (camera bus),
//        we/wAddr/wData (frame buffer write port), frame_done (end-of-frame pulse)
module ov7670_frame_writer #(
   parameter int H_PIXELS = 320,
   parameter int V_LINES  = 240,
   parameter int ADDR_W   = 17
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              vsync,
   input  logic              href,
   input  logic [7:0]        data,
   output logic              we,
   output logic [ADDR_W-1:0] wAddr,
   output logic [15:0]       wData,
   output logic              frame_done
);
   localparam int X_W = $clog2(H_PIXELS + 1);
   localparam int Y_W = $clog2(V_LINES + 1);
   typedef enum logic [1:0] {SYNC, BLANK, ACTIVE} state_t;
   state_t            state_q, state_d;
   logic [X_W-1:0]    x_q, x_d;
   logic [Y_W-1:0]    y_q, y_d;
   logic [ADDR_W-1:0] line_base_q, line_base_d, waddr_q, waddr_d;
   logic [15:0]       wdata_q, wdata_d;
   logic [7:0]        hi_q, hi_d;
   logic              phase_q, phase_d, we_q, we_d, fd_q, fd_d, vsync_q, href_q;
   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      line_base_d = line_base_q;
      hi_d        = hi_q;
      phase_d     = phase_q;
      we_d        = 1'b0;
      waddr_d     = waddr_q;
      wdata_d     = wdata_q;
      fd_d        = 1'b0;
      case (state_q)
         SYNC:  if (vsync) state_d = BLANK;
         BLANK: if (vsync_q && !vsync) begin
            x_d         = '0;
            y_d         = '0;
            line_base_d = '0;
            phase_d     = 1'b0;
            state_d     = ACTIVE;
         end
         ACTIVE: begin
            if (!vsync_q && vsync) begin
               fd_d    = 1'b1;
               state_d = BLANK;
            end
            if (href) begin
               if (!phase_q) begin
                  hi_d    = data;
                  phase_d = 1'b1;
               end else begin
                  phase_d = 1'b0;
                  if (x_q < X_W'(H_PIXELS) && y_q < Y_W'(V_LINES)) begin
                     we_d    = 1'b1;
                     wdata_d = {hi_q, data};
                     waddr_d = line_base_q + ADDR_W'(x_q);
                  end
                  if (x_q != X_W'(H_PIXELS)) x_d = x_q + 1'b1;
               end
            end else if (href_q) begin
               // line end; a trailing unpaired byte is dropped via the phase reset
               phase_d = 1'b0;
               if (x_q != '0) begin
                  x_d = '0;
                  // once lines saturate, line_base is frozen so it can never wrap
                  if (y_q != Y_W'(V_LINES)) begin
                     y_d         = y_q + 1'b1;
                     line_base_d = line_base_q + ADDR_W'(H_PIXELS);
                  end
               end
            end
         end
         default: state_d = SYNC;
      endcase
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= SYNC;
         x_q         <= '0;
         y_q         <= '0;
         line_base_q <= '0;
         hi_q        <= '0;
         phase_q     <= 1'b0;
         we_q        <= 1'b0;
         waddr_q     <= '0;
         wdata_q     <= '0;
         fd_q        <= 1'b0;
         vsync_q     <= 1'b1;
         href_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         line_base_q <= line_base_d;
         hi_q        <= hi_d;
         phase_q     <= phase_d;
         we_q        <= we_d;
         waddr_q     <= waddr_d;
         wdata_q     <= wdata_d;
         fd_q        <= fd_d;
         vsync_q     <= vsync;
         href_q      <= href;
      end
   end
   assign we         = we_q;
   assign wAddr      = waddr_q;
   assign wData      = wdata_q;
   assign frame_done = fd_q;
endmodule

// File: tb/tb_ov7670_frame_writer.sv
// tb_ov7670_frame_writer: directed bench on a scaled 8x6 frame buffer
module tb_ov7670_frame_writer;
   localparam int H = 8;
   localparam int V = 6;
   localparam int AW = 17;
   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          vsync = 1'b0;
   logic          href = 1'b0;
   logic [7:0]    data = 8'h00;
   logic          we;
   logic [AW-1:0] wAddr;
   logic [15:0]   wData;
   logic          frame_done;
   int            checks = 0;
   int            passed = 0;
   int            fd_cycles = 0;
   logic [AW-1:0] log_addr[$];
   logic [15:0]   log_data[$];
   ov7670_frame_writer #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) dut (
      .clk(clk), .reset_n(reset_n), .vsync(vsync), .href(href), .data(data),
      .we(we), .wAddr(wAddr), .wData(wData), .frame_done(frame_done)
   );
   always #5 clk = ~clk;
   always @(negedge clk) begin
      if (we === 1'b1) begin
         log_addr.push_back(wAddr);
         log_data.push_back(wData);
      end
      if (frame_done === 1'b1) fd_cycles++;
   end
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic clear_log();
      log_addr.delete();
      log_data.delete();
      fd_cycles = 0;
   endtask
   task automatic send_byte(input logic [7:0] b);
      href = 1'b1;
      data = b;
      tick(1);
   endtask
   task automatic send_line(input int n, input logic [7:0] start);
      for (int j = 0; j < n; j++) send_byte(start + 8'(j));
      href = 1'b0;
      tick(3);
   endtask
   task automatic end_frame();
      href = 1'b0;
      vsync = 1'b1;
      tick(3);
   endtask
   task automatic new_frame();
      end_frame();
      vsync = 1'b0;
      tick(2);
      clear_log();
   endtask
   task automatic test_reset();
      #1;
      checks++; if (we !== 1'b0) $display("FAIL reset_we: got %b want 0", we); else passed++;
      checks++; if (wAddr !== '0) $display("FAIL reset_waddr: got %0d want 0", wAddr); else passed++;
      checks++; if (wData !== 16'h0) $display("FAIL reset_wdata: got %h want 0000", wData); else passed++;
      checks++; if (frame_done !== 1'b0) $display("FAIL reset_fd: got %b want 0", frame_done); else passed++;
   endtask
   task automatic test_sync_gating();
      tick(2);
      reset_n = 1'b1;
      tick(1);
      send_line(6, 8'h10);
      checks++; if (log_addr.size() !== 0) $display("FAIL sync_no_write: got %0d writes want 0", log_addr.size()); else passed++;
      vsync = 1'b1;
      tick(3);
      vsync = 1'b0;
      tick(2);
      checks++; if (log_addr.size() !== 0) $display("FAIL blank_no_write: got %0d writes want 0", log_addr.size()); else passed++;
   endtask
   task automatic test_first_pixel();
      send_byte(8'hF8);
      checks++; if (we !== 1'b0) $display("FAIL first_half_we: got %b want 0", we); else passed++;
      send_byte(8'h1F);
      checks++; if (we !== 1'b1) $display("FAIL first_we: got %b want 1", we); else passed++;
      checks++; if (wAddr !== 0) $display("FAIL first_addr: got %0d want 0", wAddr); else passed++;
      checks++; if (wData !== 16'hF81F) $display("FAIL first_data: got %h want f81f", wData); else passed++;
      href = 1'b0;
      tick(1);
      checks++; if (we !== 1'b0) $display("FAIL first_we_drop: got %b want 0", we); else passed++;
      checks++; if (wData !== 16'hF81F) $display("FAIL held_data: got %h want f81f", wData); else passed++;
   endtask
   task automatic test_full_frame();
      int bad = 0;
      new_frame();
      for (int l = 0; l < V; l++) send_line(2 * H, 8'(l * 2 * H));
      end_frame();
      checks++; if (log_addr.size() !== H * V) $display("FAIL full_count: got %0d want %0d", log_addr.size(), H * V); else passed++;
      for (int i = 0; i < log_addr.size(); i++)
         if (log_addr[i] !== AW'(i) || log_data[i] !== {8'(2 * i), 8'(2 * i + 1)}) bad++;
      checks++; if (bad !== 0) $display("FAIL full_order: got %0d bad entries want 0", bad); else passed++;
      checks++; if (log_addr.size() > H && log_addr[H] !== AW'(H)) $display("FAIL line1_start: got %0d want %0d", log_addr[H], H); else passed++;
      checks++; if (fd_cycles !== 1) $display("FAIL full_fd: got %0d cycles want 1", fd_cycles); else passed++;
   endtask
   task automatic test_long_line();
      new_frame();
      send_line(2 * H, 8'h00);
      send_line(2 * (H + 2) + 1, 8'h40);
      send_line(4, 8'hA0);
      end_frame();
      checks++; if (log_addr.size() !== 2 * H + 2) $display("FAIL long_count: got %0d want %0d", log_addr.size(), 2 * H + 2); else passed++;
      if (log_addr.size() >= 2 * H + 2) begin
         checks++; if (log_addr[2 * H - 1] !== AW'(2 * H - 1)) $display("FAIL long_last_addr: got %0d want %0d", log_addr[2 * H - 1], 2 * H - 1); else passed++;
         checks++; if (log_data[2 * H - 1] !== 16'h4E4F) $display("FAIL long_last_data: got %h want 4e4f", log_data[2 * H - 1]); else passed++;
         checks++; if (log_addr[2 * H] !== AW'(2 * H)) $display("FAIL next_line_addr: got %0d want %0d", log_addr[2 * H], 2 * H); else passed++;
         checks++; if (log_data[2 * H] !== 16'hA0A1) $display("FAIL odd_byte_dropped: got %h want a0a1", log_data[2 * H]); else passed++;
      end
   endtask
   task automatic test_extra_lines();
      logic [AW-1:0] mx = '0;
      new_frame();
      for (int l = 0; l < V + 2; l++) send_line(2 * H, 8'h55);
      end_frame();
      foreach (log_addr[i]) if (log_addr[i] > mx) mx = log_addr[i];
      checks++; if (log_addr.size() !== H * V) $display("FAIL extra_count: got %0d want %0d", log_addr.size(), H * V); else passed++;
      checks++; if (mx !== AW'(H * V - 1)) $display("FAIL extra_max_addr: got %0d want %0d", mx, H * V - 1); else passed++;
      checks++; if (fd_cycles !== 1) $display("FAIL extra_fd: got %0d cycles want 1", fd_cycles); else passed++;
   endtask
   task automatic test_early_vsync();
      new_frame();
      for (int l = 0; l < 3; l++) send_line(4, 8'h20);
      end_frame();
      checks++; if (log_addr.size() !== 6) $display("FAIL early_count: got %0d want 6", log_addr.size()); else passed++;
      checks++; if (fd_cycles !== 1) $display("FAIL early_fd: got %0d cycles want 1", fd_cycles); else passed++;
      new_frame();
      send_line(2, 8'h77);
      checks++; if (log_addr.size() !== 1 || log_addr[0] !== 0) $display("FAIL early_restart: got %0d writes want 1 at addr 0", log_addr.size()); else passed++;
   endtask
   task automatic test_midframe_reset();
      new_frame();
      for (int l = 0; l < 3; l++) send_line(2 * H, 8'h30);
      send_byte(8'hAB);
      send_byte(8'hCD);
      checks++; if (we !== 1'b1 || wAddr !== AW'(3 * H)) $display("FAIL pre_reset_write: got we=%b addr=%0d want we=1 addr=%0d", we, wAddr, 3 * H); else passed++;
      #2 reset_n = 1'b0;
      #1;
      checks++; if (we !== 1'b0 || wAddr !== '0) $display("FAIL async_reset: got we=%b addr=%0d want we=0 addr=0", we, wAddr); else passed++;
      href = 1'b0;
      tick(2);
      #3 reset_n = 1'b1;
      tick(1);
      clear_log();
      send_line(8, 8'h60);
      checks++; if (log_addr.size() !== 0) $display("FAIL post_reset_gated: got %0d writes want 0", log_addr.size()); else passed++;
      new_frame();
      send_line(2, 8'h12);
      checks++; if (log_addr.size() !== 1 || log_addr[0] !== 0 || log_data[0] !== 16'h1213) $display("FAIL resume_capture: got %0d writes want 1 at addr 0 data 1213", log_addr.size()); else passed++;
   endtask
   initial begin
      test_reset();
      test_sync_gating();
      test_first_pixel();
      test_full_frame();
      test_long_line();
      test_extra_lines();
      test_early_vsync();
      test_midframe_reset();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/ov7670_frame_writer.md
Name: ov7670_frame_writer

Overview:
- Camera-capture stage that fills the QVGA RGB565 frame buffer, which the VGA read side later scans out.
- Deserialises the OV7670 8-bit byte stream (two bytes per pixel, high byte first), gated by HREF and VSYNC.
- Produces write strobes, linear addresses (line*H_PIXELS + x) and 16-bit pixel words for the frame buffer's write port.
- Runs entirely in the camera pixel-clock domain.

Parameters:
H_PIXELS, 320, pixels per line written to the buffer
V_LINES, 240, lines per frame written to the buffer
ADDR_W, 17, frame buffer address width (must hold H_PIXELS*V_LINES-1)

Ports:
clk  input  1  camera PCLK; all inputs sampled on rising edge
reset_n  input  1  asynchronous active-low reset
vsync  input  1  camera VSYNC, high = vertical blanking
href  input  1  camera HREF, high = valid bytes on data
data  input  8  camera byte bus
we  output  1  frame buffer write enable, one cycle per pixel
wAddr  output  ADDR_W  frame buffer write address
wData  output  16  RGB565 pixel {byte0, byte1}
frame_done  output  1  one-cycle pulse at end of a captured frame

Behaviour:
- Reset (async, reset_n=0) sets the following, all registered:
  - we=0, wAddr=0, wData=0, frame_done=0.
  - State=SYNC; x_cnt, y_cnt, line_base and byte phase all 0.
  - vsync_d=1 and href_d=0.
- FSM:
  - SYNC: ignores all bytes. Moves to BLANK on the first cycle vsync=1. Prevents capturing a partial frame after reset.
  - BLANK: vsync=1. On the vsync falling edge (vsync_d=1, vsync=0), clears x_cnt, y_cnt, line_base and phase, then moves to ACTIVE.
  - ACTIVE: captures bytes. On the vsync rising edge (vsync_d=0, vsync=1), pulses frame_done for exactly one cycle (the next cycle) and moves to BLANK. This applies whether or not V_LINES lines were received.
- Byte assembly, ACTIVE with href=1:
  - phase=0: latch data into hi_byte, set phase=1.
  - phase=1: set phase=0 and form pixel {hi_byte, data}.
  - If x_cnt<H_PIXELS and y_cnt<V_LINES, the next cycle has we=1, wData={hi_byte,data}, wAddr=line_base+x_cnt.
  - x_cnt increments on every completed pixel, saturating at H_PIXELS.
  - Latency: we is asserted one clk after the second byte is sampled. we is high for exactly one cycle per accepted pixel.
- Line end: a href falling edge (href_d=1, href=0) in ACTIVE.
  - If x_cnt>0: y_cnt++ (saturating at V_LINES), line_base+=H_PIXELS, x_cnt=0.
  - Always: phase=0. An unpaired trailing byte is discarded with no write.
  - An href pulse with zero completed pixels does not advance the line.
- Overflow:
  - Pixels beyond H_PIXELS in a line are dropped.
  - Lines beyond V_LINES are dropped.
  - wAddr never exceeds H_PIXELS*V_LINES-1.
- Address arithmetic:
  - Adder only, no multiplier.
  - line_base and wAddr are ADDR_W wide; x_cnt is clog2(H_PIXELS+1) bits.
- Held outputs: when we=0, wAddr and wData hold their last values.
- href outside ACTIVE (in SYNC/BLANK) is ignored. href_d still tracks.
- Mid-frame reset: outputs clear immediately (async). After release the block re-enters SYNC and waits for a full vsync cycle before writing.

Test Plan:
- Release reset with vsync=0, href active with bytes -> no we until vsync goes 1 then 0. First frame after that: bytes 0xF8,0x1F on line 0 -> we=1 one cycle later, wAddr=0, wData=0xF81F.
- Full frame, 240 lines × 640 bytes of incrementing pattern, then vsync rise -> exactly 76800 we pulses. wAddr runs 0..76799 in order. Line 1 starts at wAddr=320. frame_done high for exactly 1 cycle.
- Line of 661 bytes (330 pixels + 1 odd byte) -> exactly 320 writes on that line, last wAddr=line_base+319. Odd byte produces no write. Next line starts at line_base+320.
- 250 lines per frame -> no write beyond wAddr=76799. frame_done still pulses at vsync rise.
- vsync rises after 100 lines -> frame_done pulse. The next frame's first pixel writes wAddr=0.
- reset_n asserted mid-line at pixel 50 of line 10 -> we=0 and wAddr=0 immediately. No writes until a fresh vsync high→low. Capture then resumes at wAddr=0.
